// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, field constants, FSM encoding and the
// GF(2^8) / affine helpers used by every S-box lane.
package aes_pkg;

  localparam int unsigned AES_STATE_W   = 128;
  localparam int unsigned AES_BYTES     = 16;
  localparam logic [8:0]  GF_POLY       = 9'h11B;
  localparam logic [7:0]  SBOX_AFFINE_C = 8'h63;
  localparam logic [7:0]  INV_AFFINE_C  = 8'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Shift-and-add multiply, reducing by the AES polynomial on each shift.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ GF_POLY[7:0]) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), x);
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ SBOX_AFFINE_C;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ INV_AFFINE_C;
  endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// Input/output handshake bundle of the SubBytes engine.
// The inv mode port exists only when INV_SBOX_EN is defined.
interface sub_bytes_engine_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_data;
  logic                   busy;
`ifdef INV_SBOX_EN
  logic                   inv;
`endif

  modport master (
`ifdef INV_SBOX_EN
    output inv,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
`ifdef INV_SBOX_EN
    input  inv,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/sbox_lane.sv
// One combinational S-box lane: GF inverse plus affine transform.
// With INV_SBOX_EN, i_inv selects inverse-affine followed by GF inverse.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
`ifdef INV_SBOX_EN
  input  logic       i_inv,
`endif
  output logic [7:0] o_byte
);

`ifdef INV_SBOX_EN
  assign o_byte = i_inv ? gf_inv(inv_affine(i_byte)) : sbox_affine(gf_inv(i_byte));
`else
  assign o_byte = sbox_affine(gf_inv(i_byte));
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// Sequential SubBytes over a 128-bit state, BYTES_PER_CYCLE lanes per clock.
// Optional InvSubBytes mode under INV_SBOX_EN.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  sub_bytes_engine_if.slave  bus
);

  localparam int unsigned   STATE_W  = AES_STATE_W;
  localparam int unsigned   CNT_W    = 5;
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(BYTES_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(AES_BYTES - BYTES_PER_CYCLE);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  aes_state_e                        r_state;
  logic [AES_BYTES-1:0][7:0]         r_work;
  logic [AES_BYTES-1:0][7:0]         w_work_next;
  logic [CNT_W-1:0]                  r_cnt;
  logic                              r_in_ready;
  logic                              r_out_valid;
  logic                              r_busy;
  logic [STATE_W-1:0]                r_out_data;
  logic [BYTES_PER_CYCLE-1:0][3:0]   w_lane_pos;
  logic [BYTES_PER_CYCLE-1:0][7:0]   w_lane_in;
  logic [BYTES_PER_CYCLE-1:0][7:0]   w_lane_out;
`ifdef INV_SBOX_EN
  logic                              r_inv;
`endif

  // Byte 0 sits in the top bits, so packed index = 15 - byte number.
  for (genvar g = 0; g < int'(BYTES_PER_CYCLE); g++) begin : g_lane
    assign w_lane_pos[g] = 4'(AES_BYTES - 1) - (r_cnt[3:0] + 4'(g));
    assign w_lane_in[g]  = r_work[w_lane_pos[g]];

    sbox_lane u_lane (
      .i_byte (w_lane_in[g]),
`ifdef INV_SBOX_EN
      .i_inv  (r_inv),
`endif
      .o_byte (w_lane_out[g])
    );
  end

  always_comb begin
    w_work_next = r_work;
    for (int k = 0; k < int'(BYTES_PER_CYCLE); k++) begin
      w_work_next[w_lane_pos[k]] = w_lane_out[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
`ifdef INV_SBOX_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (bus.in_valid && r_in_ready) begin
            r_work     <= bus.in_data;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= BUSY;
`ifdef INV_SBOX_EN
            r_inv      <= bus.inv;
`endif
          end
        end
        BUSY: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt + STEP;
          if (r_cnt == LAST_CNT) begin
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_work_next;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;

endmodule
